// File: rtl/control_inv2x2_mxb_if.sv
// control_inv2x2_mxb_if: control/status bundle between the MxB inversion sequencer and its datapath
interface control_inv2x2_mxb_if #(parameter int AW = 4);
   logic [AW-1:0] ra_mxb;
   logic [AW-1:0] wa_mxc;
   logic          ld_opa;
   logic          ld_opb;
   logic          mul_start;
   logic          mul_done;
   logic [1:0]    acc_op;
   logic          det_zero;
   logic          div_start;
   logic          div_neg;
   logic          div_done;
   logic          we_mxc;
   modport master (
      output ra_mxb, ld_opa, ld_opb, mul_start, acc_op, div_start, div_neg, wa_mxc, we_mxc,
      input  mul_done, det_zero, div_done
   );
   modport slave (
      input  ra_mxb, ld_opa, ld_opb, mul_start, acc_op, div_start, div_neg, wa_mxc, we_mxc,
      output mul_done, det_zero, div_done
   );
endinterface

// File: rtl/control_inv2x2_mxb.sv
// control_inv2x2_mxb: sequences det(B), singular check and four divides writing inv(B) into MxC
module control_inv2x2_mxb #(
  parameter int TIMEOUT_CYC = 64,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic [AW-1:0] ra_mxb,
  output logic          ld_opa,
  output logic          ld_opb,
  output logic          mul_start,
  input  logic          mul_done,
  output logic [1:0]    acc_op,
  input  logic          det_zero,
  output logic          div_start,
  output logic          div_neg,
  input  logic          div_done,
  output logic [AW-1:0] wa_mxc,
  output logic          we_mxc,
  output logic          busy,
  output logic          done,
  output logic          err_singular
`ifdef CTRL_INV2X2_TIMEOUT_EN
  , output logic        err_timeout
`endif
);
  localparam logic [3:0] IDLE = 4'd0, RD_A = 4'd1, RD_B = 4'd2, MUL = 4'd3, WAIT_MUL = 4'd4, ACC = 4'd5,
                         CHK = 4'd6, RD_D = 4'd7, DIV = 4'd8, WAIT_DIV = 4'd9, WR = 4'd10, DONE = 4'd11;
  logic [3:0] st, ns;
  logic       term, nterm;
  logic [1:0] ent, nent;
  logic       to;
`ifdef CTRL_INV2X2_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYC + 1);
  logic [WW-1:0] wcnt;
  assign to = wcnt == WW'(TIMEOUT_CYC - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) wcnt <= '0;
    else wcnt <= (ns != st) ? '0 : wcnt + 1'b1;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) err_timeout <= 1'b0;
    else if (st == IDLE && start) err_timeout <= 1'b0;
    else if (to && ((st == WAIT_MUL && !mul_done) || (st == WAIT_DIV && !div_done))) err_timeout <= 1'b1;
`else
  assign to = 1'b0;
`endif
  always_comb begin
    ns = st;
    nterm = term;
    nent = ent;
    case (st)
      IDLE:     if (start) begin ns = RD_A; nterm = 1'b0; nent = 2'd0; end
      RD_A:     ns = RD_B;
      RD_B:     ns = MUL;
      MUL:      ns = WAIT_MUL;
      WAIT_MUL: ns = mul_done ? ACC : to ? DONE : WAIT_MUL;
      ACC:      begin ns = term ? CHK : RD_A; nterm = 1'b1; end
      CHK:      begin ns = det_zero ? DONE : RD_D; nent = 2'd0; end
      RD_D:     ns = DIV;
      DIV:      ns = WAIT_DIV;
      WAIT_DIV: ns = div_done ? WR : to ? DONE : WAIT_DIV;
      WR:       begin ns = &ent ? DONE : RD_D; nent = ent + {1'b0, ~&ent}; end
      default:  ns = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st           <= IDLE;
      term         <= 1'b0;
      ent          <= 2'd0;
      ra_mxb       <= '0;
      ld_opa       <= 1'b0;
      ld_opb       <= 1'b0;
      mul_start    <= 1'b0;
      acc_op       <= 2'b00;
      div_start    <= 1'b0;
      div_neg      <= 1'b0;
      wa_mxc       <= '0;
      we_mxc       <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err_singular <= 1'b0;
    end else begin
      st           <= ns;
      term         <= nterm;
      ent          <= nent;
      ra_mxb       <= (ns == RD_A) ? AW'(nterm) :
                      (ns == RD_B) ? AW'({1'b1, ~nterm}) :
                      (ns == RD_D) ? AW'({~nent[0], ~nent[1]}) : '0;
      ld_opa       <= ns == RD_A || ns == RD_D;
      ld_opb       <= ns == RD_B;
      mul_start    <= ns == MUL;
      acc_op       <= (ns == ACC) ? (nterm ? 2'b10 : 2'b01) : 2'b00;
      div_start    <= ns == DIV;
      div_neg      <= ns == DIV && (nent[0] ^ nent[1]);
      wa_mxc       <= (ns == WR) ? AW'(nent) : '0;
      we_mxc       <= ns == WR;
      busy         <= ns != IDLE;
      done         <= ns == DONE;
      err_singular <= (st == IDLE && start) ? 1'b0 : (st == CHK && det_zero) ? 1'b1 : err_singular;
    end
endmodule
